// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-sweep controller driving the DDS phase increment.
// Optional up-and-back sweeping is compiled in with `define SWEEP_BIDIR_EN.
module dds_sweep_ctrl #(
  parameter int DWELL_W = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               continuous,
  input  logic               bidir,
  input  logic [31:0]        f_start,
  input  logic [31:0]        f_stop,
  input  logic [31:0]        f_step,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [31:0]        manual_inc,
  output logic [31:0]        dac_freq_poff,
  output logic               sweep_busy,
  output logic               step_strobe,
  output logic               sweep_done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN_FWD = 2'd1
`ifdef SWEEP_BIDIR_EN
    , RUN_REV = 2'd2
`endif
  } state_t;

  state_t             state_r, state_s;
  logic [31:0]        f_start_r, f_stop_r, f_step_r;
  logic [DWELL_W-1:0] dwell_r, dwell_cnt_r, dwell_cnt_s;
  logic               cont_r;
  logic [31:0]        dac_s;
  logic               busy_s, strobe_s, done_s;
  logic               load_s, pass_end_s, go_idle_s;
  logic               up_s, dwell_done_s, at_stop_s;

`ifdef SWEEP_BIDIR_EN
  logic               bidir_r;
  logic               at_start_s;
`else
  logic               bidir_unused_s;
  assign bidir_unused_s = bidir;
`endif

  // Step one increment toward target in 33 bits; any overshoot or wrap clamps to target.
  function automatic logic [31:0] step_toward(input logic [31:0] cur, input logic [31:0] step,
                                              input logic [31:0] target, input logic up);
    logic [32:0] sum;
    logic [31:0] res;
    if (up) begin
      sum = {1'b0, cur} + {1'b0, step};
      if (sum[32] || (sum[31:0] > target)) res = target;
      else                                 res = sum[31:0];
    end else begin
      sum = {1'b0, cur} - {1'b0, step};
      if (sum[32] || (sum[31:0] < target)) res = target;
      else                                 res = sum[31:0];
    end
    return res;
  endfunction

  assign up_s         = (f_stop_r >= f_start_r);
  assign dwell_done_s = (dwell_cnt_r == dwell_r);
  // A zero step degenerates to a single-point pass at f_start.
  assign at_stop_s    = (dac_freq_poff == f_stop_r) || (f_step_r == 32'd0);
`ifdef SWEEP_BIDIR_EN
  assign at_start_s   = (dac_freq_poff == f_start_r);
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_s     = state_r;
    dac_s       = dac_freq_poff;
    busy_s      = sweep_busy;
    strobe_s    = 1'b0;
    done_s      = 1'b0;
    dwell_cnt_s = dwell_cnt_r;
    load_s      = 1'b0;
    pass_end_s  = 1'b0;
    go_idle_s   = 1'b0;

    case (state_r)
      IDLE: begin
        dac_s  = manual_inc;
        busy_s = 1'b0;
        if (start && !abort) begin
          load_s      = 1'b1;
          state_s     = RUN_FWD;
          dac_s       = f_start;
          busy_s      = 1'b1;
          strobe_s    = 1'b1;
          dwell_cnt_s = {DWELL_W{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      RUN_FWD: begin
        if (abort) begin
          go_idle_s = 1'b1;
        end else if (!dwell_done_s) begin
          dwell_cnt_s = dwell_cnt_r + DWELL_W'(1);
        end else if (at_stop_s) begin
`ifdef SWEEP_BIDIR_EN
          if (bidir_r && (f_step_r != 32'd0) && (f_start_r != f_stop_r)) begin
            state_s     = RUN_REV;
            dac_s       = step_toward(dac_freq_poff, f_step_r, f_start_r, !up_s);
            strobe_s    = 1'b1;
            dwell_cnt_s = {DWELL_W{1'b0}};
          end else begin
            pass_end_s = 1'b1;
          end
`else
          pass_end_s = 1'b1;
`endif
        end else begin
          dac_s       = step_toward(dac_freq_poff, f_step_r, f_stop_r, up_s);
          strobe_s    = 1'b1;
          dwell_cnt_s = {DWELL_W{1'b0}};
        end
      end
`ifdef SWEEP_BIDIR_EN
      RUN_REV: begin
        if (abort) begin
          go_idle_s = 1'b1;
        end else if (!dwell_done_s) begin
          dwell_cnt_s = dwell_cnt_r + DWELL_W'(1);
        end else if (at_start_s) begin
          pass_end_s = 1'b1;
        end else begin
          dac_s       = step_toward(dac_freq_poff, f_step_r, f_start_r, !up_s);
          strobe_s    = 1'b1;
          dwell_cnt_s = {DWELL_W{1'b0}};
        end
      end
`endif
      default: begin
        go_idle_s = 1'b1;
      end
    endcase

    if (go_idle_s) begin
      state_s     = IDLE;
      dac_s       = manual_inc;
      busy_s      = 1'b0;
      dwell_cnt_s = {DWELL_W{1'b0}};
    end else if (pass_end_s) begin
      done_s      = 1'b1;
      dwell_cnt_s = {DWELL_W{1'b0}};
      if (cont_r) begin
        state_s  = RUN_FWD;
        dac_s    = f_start_r;
        strobe_s = 1'b1;
      end else begin
        state_s = IDLE;
        dac_s   = manual_inc;
        busy_s  = 1'b0;
      end
    end else begin
      done_s = 1'b0;
    end
  end

  // State, outputs, dwell counter and sweep parameters latched at start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      dac_freq_poff <= 32'd0;
      sweep_busy    <= 1'b0;
      step_strobe   <= 1'b0;
      sweep_done    <= 1'b0;
      dwell_cnt_r   <= {DWELL_W{1'b0}};
      f_start_r     <= 32'd0;
      f_stop_r      <= 32'd0;
      f_step_r      <= 32'd0;
      dwell_r       <= {DWELL_W{1'b0}};
      cont_r        <= 1'b0;
`ifdef SWEEP_BIDIR_EN
      bidir_r       <= 1'b0;
`endif
    end else begin
      state_r       <= state_s;
      dac_freq_poff <= dac_s;
      sweep_busy    <= busy_s;
      step_strobe   <= strobe_s;
      sweep_done    <= done_s;
      dwell_cnt_r   <= dwell_cnt_s;
      if (load_s) begin
        f_start_r <= f_start;
        f_stop_r  <= f_stop;
        f_step_r  <= f_step;
        dwell_r   <= dwell;
        cont_r    <= continuous;
`ifdef SWEEP_BIDIR_EN
        bidir_r   <= bidir;
`endif
      end
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: sequence-level reference model checked every cycle plus directed literal checks.
module tb_dds_sweep_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, start, abort, continuous, bidir;
  logic [31:0] f_start, f_stop, f_step, manual_inc;
  logic [23:0] dwell;
  logic [31:0] dac_freq_poff;
  logic        sweep_busy, step_strobe, sweep_done;

  int n_tests = 0;
  int n_fail  = 0;

  dds_sweep_ctrl #(.DWELL_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .continuous(continuous),
    .bidir(bidir), .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .dwell(dwell),
    .manual_inc(manual_inc), .dac_freq_poff(dac_freq_poff), .sweep_busy(sweep_busy),
    .step_strobe(step_strobe), .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a pass is the precomputed list of per-cycle output values.
  logic [31:0] m_dac;
  logic        m_busy, m_strobe, m_done;
  bit          m_active;
  logic [31:0] m_seq[$];
  int          m_pos, m_per;
  bit          m_cont;

  function automatic logic [31:0] toward(input logic [31:0] v, input logic [31:0] s, input logic [31:0] tgt);
    longint nv;
    longint lt;
    lt = {32'h0, tgt};
    if (tgt >= v) begin
      nv = {32'h0, v} + {32'h0, s};
      if (nv > lt) nv = lt;
    end else begin
      nv = {32'h0, v} - {32'h0, s};
      if (nv < lt) nv = lt;
    end
    return nv[31:0];
  endfunction

  task automatic build_pass();
    logic [31:0] vals[$];
    logic [31:0] v;
    vals.delete();
    m_seq.delete();
    v = f_start;
    vals.push_back(v);
    if (f_step != 32'd0 && f_start != f_stop) begin
      while (v != f_stop) begin
        v = toward(v, f_step, f_stop);
        vals.push_back(v);
      end
`ifdef SWEEP_BIDIR_EN
      if (bidir) begin
        while (v != f_start) begin
          v = toward(v, f_step, f_start);
          vals.push_back(v);
        end
      end
`endif
    end
    m_per  = int'(dwell) + 1;
    m_cont = continuous;
    foreach (vals[i]) for (int k = 0; k < m_per; k++) m_seq.push_back(vals[i]);
  endtask

  task automatic model_step();
    m_strobe = 1'b0;
    m_done   = 1'b0;
    if (!rst_n) begin
      m_active = 1'b0; m_dac = 32'd0; m_busy = 1'b0;
    end else if (!m_active) begin
      if (start && !abort) begin
        build_pass();
        m_active = 1'b1; m_pos = 0; m_dac = m_seq[0]; m_busy = 1'b1; m_strobe = 1'b1;
      end else begin
        m_dac = manual_inc; m_busy = 1'b0;
      end
    end else if (abort) begin
      m_active = 1'b0; m_dac = manual_inc; m_busy = 1'b0;
    end else begin
      m_pos++;
      if (m_pos == m_seq.size()) begin
        m_done = 1'b1;
        if (m_cont) begin
          m_pos = 0; m_dac = m_seq[0]; m_strobe = 1'b1; m_busy = 1'b1;
        end else begin
          m_active = 1'b0; m_dac = manual_inc; m_busy = 1'b0;
        end
      end else begin
        m_dac = m_seq[m_pos]; m_busy = 1'b1; m_strobe = (m_pos % m_per) == 0;
      end
    end
  endtask

  // Observation counters for the directed checks.
  int          n_strobe, n_busy, n_done;
  logic [31:0] seen[$];

  task automatic clear_obs();
    n_strobe = 0; n_busy = 0; n_done = 0; seen.delete();
  endtask

  initial begin
    m_active = 1'b0;
    clear_obs();
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("dac_freq_poff", dac_freq_poff, m_dac);
      check("sweep_busy", {31'd0, sweep_busy}, {31'd0, m_busy});
      check("step_strobe", {31'd0, step_strobe}, {31'd0, m_strobe});
      check("sweep_done", {31'd0, sweep_done}, {31'd0, m_done});
      if (step_strobe) begin n_strobe++; seen.push_back(dac_freq_poff); end
      if (sweep_busy) n_busy++;
      if (sweep_done) n_done++;
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic pulse_start();
    tick(); start = 1'b1;
    tick(); start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int c;
    c = 0;
    while (sweep_busy && c < 2000) begin tick(); c++; end
    check({name, "_timeout"}, {31'd0, sweep_busy}, 32'd0);
  endtask

  task automatic setup(input logic [31:0] fs, input logic [31:0] fe, input logic [31:0] st,
                       input logic [23:0] dw, input logic cont, input logic bd);
    f_start = fs; f_stop = fe; f_step = st; dwell = dw; continuous = cont; bidir = bd;
    clear_obs();
  endtask

  task automatic check_seen(input string name, input logic [31:0] exp[$]);
    check({name, "_len"}, seen.size(), exp.size());
    for (int i = 0; i < exp.size() && i < seen.size(); i++) check(name, seen[i], exp[i]);
  endtask

  initial begin
    int c;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; continuous = 1'b0; bidir = 1'b0;
    f_start = 32'd0; f_stop = 32'd0; f_step = 32'd0; dwell = 24'd0; manual_inc = 32'h0010_0000;

    // reset then idle
    repeat (3) tick();
    check("reset_dac", dac_freq_poff, 32'd0);
    check("reset_busy", {31'd0, sweep_busy}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_passthru", dac_freq_poff, 32'h0010_0000);

    // single up sweep
    setup(32'd100, 32'd130, 32'd10, 24'd2, 1'b0, 1'b0);
    pulse_start();
    wait_idle("up");
    check_seen("up_vals", '{32'd100, 32'd110, 32'd120, 32'd130});
    check("up_strobes", n_strobe, 32'd4);
    check("up_busy", n_busy, 32'd12);
    check("up_done", n_done, 32'd1);
    check("up_back_manual", dac_freq_poff, 32'h0010_0000);

    // clamp down
    setup(32'd50, 32'd20, 32'd20, 24'd0, 1'b0, 1'b0);
    pulse_start();
    wait_idle("down");
    check_seen("down_vals", '{32'd50, 32'd30, 32'd20});
    check("down_done", n_done, 32'd1);

    // overflow clamp at top of range
    setup(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 24'd0, 1'b0, 1'b0);
    pulse_start();
    wait_idle("ovf");
    check_seen("ovf_vals", '{32'hFFFF_FFF0, 32'hFFFF_FFFF});

    // continuous with abort on the second value of pass 3
    setup(32'd100, 32'd120, 32'd10, 24'd0, 1'b1, 1'b0);
    pulse_start();
    c = 0;
    while (!(n_done == 2 && dac_freq_poff == 32'd110) && c < 200) begin tick(); c++; end
    check("cont_reach_pass3", {31'd0, (c < 200)}, 32'd1);
    abort = 1'b1;
    tick(); abort = 1'b0;
    check("cont_abort_busy", {31'd0, sweep_busy}, 32'd0);
    check("cont_abort_dac", dac_freq_poff, 32'h0010_0000);
    repeat (2) tick();
    check("cont_done_count", n_done, 32'd2);
    check_seen("cont_vals", '{32'd100, 32'd110, 32'd120, 32'd100, 32'd110, 32'd120, 32'd100, 32'd110});

    // start and abort together while idle
    setup(32'd100, 32'd130, 32'd10, 24'd0, 1'b0, 1'b0);
    tick(); start = 1'b1; abort = 1'b1;
    tick(); start = 1'b0; abort = 1'b0;
    repeat (3) tick();
    check("collide_busy", n_busy, 32'd0);

    // start while busy and f_stop change mid-sweep are ignored
    setup(32'd100, 32'd130, 32'd10, 24'd1, 1'b0, 1'b0);
    pulse_start();
    repeat (2) tick();
    f_stop = 32'd200; f_start = 32'd5;
    start = 1'b1;
    tick(); start = 1'b0;
    wait_idle("busy_start");
    check_seen("busy_start_vals", '{32'd100, 32'd110, 32'd120, 32'd130});
    check("busy_start_busy", n_busy, 32'd8);
    check("busy_start_done", n_done, 32'd1);

    // zero step: one dwell at f_start
    setup(32'd77, 32'd99, 32'd0, 24'd2, 1'b0, 1'b0);
    pulse_start();
    wait_idle("zero_step");
    check_seen("zero_step_vals", '{32'd77});
    check("zero_step_busy", n_busy, 32'd3);
    check("zero_step_done", n_done, 32'd1);

    // bidirectional request
    setup(32'd100, 32'd120, 32'd10, 24'd0, 1'b0, 1'b1);
    pulse_start();
    wait_idle("bidir");
`ifdef SWEEP_BIDIR_EN
    check_seen("bidir_vals", '{32'd100, 32'd110, 32'd120, 32'd110, 32'd100});
`else
    check_seen("bidir_vals", '{32'd100, 32'd110, 32'd120});
`endif
    check("bidir_done", n_done, 32'd1);

    // reset mid-sweep
    setup(32'd100, 32'd200, 32'd10, 24'd3, 1'b1, 1'b0);
    pulse_start();
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    check("midreset_dac", dac_freq_poff, 32'd0);
    check("midreset_busy", {31'd0, sweep_busy}, 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();
    check("midreset_idle", dac_freq_poff, 32'h0010_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
